multicycle_main_fsm: RTL

Multicycle main controller for the RISC-V core: the next-generation replacement for the single-cycle main decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the shared ALU, memory and register-file datapath, and supports variable-latency memory through a req/ready handshake. It also adds I-type ALU and jal support and keeps a retired-instruction counter.

---
 rtl/multicycle_main_fsm.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_main_fsm.sv
// Multicycle main controller: steps each RISC-V instruction through fetch, decode,
// execute, memory and writeback, with a req/ready memory handshake and a retire counter.
module multicycle_main_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b0,
  parameter bit EXT_ISA       = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pcUpdate,
  output logic             branch,
  output logic             regWrite,
  output logic             memWrite,
  output logic             irWrite,
  output logic             adrSrc,
  output logic [1:0]       resSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       immSrc,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } stateT;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  stateT curState;
  logic  rdy;
  logic  isMem;
  logic  isI;
  logic  isJal;
  logic  legal;

  // Without the handshake, memory is assumed to complete every access in one cycle.
  assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign isMem = (op == OP_LW) || (op == OP_SW);
  assign isI   = EXT_ISA && (op == OP_I);
  assign isJal = EXT_ISA && (op == OP_JAL);
  assign legal = isMem || (op == OP_R) || (op == OP_BEQ) || isI || isJal;
  assign state = curState;

  // NOTE: state and counter use non-blocking assignments so every register samples
  // the pre-edge values; blocking here would let later statements see updated state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState <= FETCH;
      instret  <= '0;
    end else begin
      if (instr_done) instret <= instret + CNT_W'(1);
      case (curState)
        FETCH:    if (rdy) curState <= DECODE;
        DECODE: begin
          if (isMem)               curState <= MEMADR;
          else if (op == OP_R)     curState <= EXECUTER;
          else if (isI)            curState <= EXECUTEI;
          else if (op == OP_BEQ)   curState <= BEQ;
          else if (isJal)          curState <= JAL;
          else                     curState <= FETCH;
        end
        MEMADR:   curState <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (rdy) curState <= MEMWB;
        MEMWB:    curState <= FETCH;
        MEMWRITE: if (rdy) curState <= FETCH;
        EXECUTER: curState <= ALUWB;
        EXECUTEI: curState <= ALUWB;
        ALUWB:    curState <= FETCH;
        BEQ:      curState <= FETCH;
        JAL:      curState <= ALUWB;
        default:  curState <= FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_req    = 1'b0;
    pcUpdate   = 1'b0;
    branch     = 1'b0;
    regWrite   = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    adrSrc     = 1'b0;
    resSrc     = 2'b00;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    aluOp      = 2'b00;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (curState)
      FETCH: begin
        mem_req  = 1'b1;
        irWrite  = rdy;
        pcUpdate = rdy;
        aluSrcB  = 2'b10;
        resSrc   = 2'b10;
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        illegal = ~legal;
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adrSrc  = 1'b1;
      end
      MEMWB: begin
        resSrc     = 2'b01;
        regWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWRITE: begin
        mem_req    = 1'b1;
        adrSrc     = 1'b1;
        memWrite   = 1'b1;
        instr_done = rdy;
      end
      EXECUTER: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      EXECUTEI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
        aluOp   = 2'b10;
      end
      ALUWB: begin
        regWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        aluSrcA    = 2'b10;
        aluOp      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      JAL: begin
        aluSrcA  = 2'b01;
        aluSrcB  = 2'b10;
        pcUpdate = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format follows the opcode in every state, including FETCH.
  always_comb begin
    immSrc = 2'b00;
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = isJal ? 2'b11 : 2'b00;
      default: immSrc = 2'b00;
    endcase
  end

endmodule
